// File: rtl/ov7725_fb_wr_ctrl.sv
// ov7725_fb_wr_ctrl: schedules SDRAM burst writes of camera pixels into a ping-pong frame buffer
module ov7725_fb_wr_ctrl #(
    parameter int          FRAME_PIXELS = 307200,
    parameter int          BURST_LEN    = 64,
    parameter int          SKIP_FRAMES  = 10,
    parameter logic [23:0] BUF0_BASE    = 24'h000000,
    parameter logic [23:0] BUF1_BASE    = 24'h100000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        sys_init_done,
    input  logic        cfg_done,
    input  logic        cam_vsync,
    input  logic [9:0]  fifo_num,
    input  logic        wr_ack,
    input  logic        wr_done,
    output logic        wr_req,
    output logic [23:0] wr_addr,
    output logic [8:0]  wr_len,
    output logic        fifo_clr,
    output logic        frame_done,
    output logic        frame_err,
    output logic        rd_bank,
    output logic        frame_valid
);
    localparam int CW = $clog2(FRAME_PIXELS + 1);
    localparam int SW = SKIP_FRAMES > 0 ? $clog2(SKIP_FRAMES + 1) : 1;

    typedef enum logic [2:0] {IDLE, SKIP, RUN, REQ, WAIT_DONE, WAIT_VS} state_t;

    state_t        state_q, state_d;
    logic [2:0]    vs_sync_q, vs_sync_d;
    logic [1:0]    cfg_sync_q, cfg_sync_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] skip_q, skip_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          frame_valid_q, frame_valid_d;
    logic          abort_q, abort_d;
    logic          wr_req_q, wr_req_d;
    logic [23:0]   wr_addr_q, wr_addr_d;
    logic [8:0]    wr_len_q, wr_len_d;
    logic          fifo_clr_q, fifo_clr_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          vs_rise;
    logic [31:0]   rem;
    logic [31:0]   done_cnt;
    logic [8:0]    len;

    assign vs_rise  = vs_sync_q[1] & ~vs_sync_q[2];
    assign rem      = 32'(FRAME_PIXELS) - 32'(count_q);
    assign len      = rem < 32'(BURST_LEN) ? 9'(rem) : 9'(BURST_LEN);
    assign done_cnt = 32'(count_q) + 32'(wr_len_q);

    // next-state: synchronizers, skip/capture sequencing, burst handshake and frame/abort bookkeeping
    always_comb begin
        vs_sync_d     = {vs_sync_q[1:0], cam_vsync};
        cfg_sync_d    = {cfg_sync_q[0], cfg_done};
        state_d       = state_q;
        count_d       = count_q;
        skip_d        = skip_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        frame_valid_d = frame_valid_q;
        abort_d       = abort_q;
        wr_req_d      = wr_req_q;
        wr_addr_d     = wr_addr_q;
        wr_len_d      = wr_len_q;
        fifo_clr_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        case (state_q)
            IDLE: state_d = (sys_init_done && cfg_sync_q[1]) ? SKIP : IDLE;
            SKIP: begin
                if (vs_rise && skip_q == SW'(SKIP_FRAMES)) begin
                    fifo_clr_d = 1'b1;
                    count_d    = '0;
                    state_d    = RUN;
                end else if (vs_rise) begin
                    skip_d = skip_q + 1'b1;
                end
            end
            RUN: begin
                if (vs_rise) begin
                    frame_err_d = 1'b1;
                    fifo_clr_d  = 1'b1;
                    count_d     = '0;
                end else if (32'(fifo_num) >= 32'(len)) begin
                    state_d   = REQ;
                    wr_req_d  = 1'b1;
                    wr_addr_d = (wr_bank_q ? BUF1_BASE : BUF0_BASE) + 24'(count_q);
                    wr_len_d  = len;
                end
            end
            REQ: begin
                abort_d = abort_q | vs_rise;
                if (wr_ack) begin
                    wr_req_d = 1'b0;
                    state_d  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                abort_d = abort_q | vs_rise;
                if (wr_done) begin
                    state_d = RUN;
                    abort_d = 1'b0;
                    if (abort_q || vs_rise) begin
                        frame_err_d = 1'b1;
                        fifo_clr_d  = 1'b1;
                        count_d     = '0;
                    end else begin
                        count_d = CW'(done_cnt);
                        if (done_cnt == 32'(FRAME_PIXELS)) begin
                            frame_done_d  = 1'b1;
                            rd_bank_d     = wr_bank_q;
                            wr_bank_d     = ~wr_bank_q;
                            frame_valid_d = 1'b1;
                            state_d       = WAIT_VS;
                        end
                    end
                end
            end
            WAIT_VS: begin
                if (vs_rise) begin
                    fifo_clr_d = 1'b1;
                    count_d    = '0;
                    state_d    = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers; asynchronous reset clears everything including any in-flight request
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            vs_sync_q     <= '0;
            cfg_sync_q    <= '0;
            count_q       <= '0;
            skip_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            abort_q       <= 1'b0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            fifo_clr_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_sync_q     <= vs_sync_d;
            cfg_sync_q    <= cfg_sync_d;
            count_q       <= count_d;
            skip_q        <= skip_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            frame_valid_q <= frame_valid_d;
            abort_q       <= abort_d;
            wr_req_q      <= wr_req_d;
            wr_addr_q     <= wr_addr_d;
            wr_len_q      <= wr_len_d;
            fifo_clr_q    <= fifo_clr_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign wr_req      = wr_req_q;
    assign wr_addr     = wr_addr_q;
    assign wr_len      = wr_len_q;
    assign fifo_clr    = fifo_clr_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign rd_bank     = rd_bank_q;
    assign frame_valid = frame_valid_q;
endmodule
